// File: rtl/fu_result_queue_if.sv
// Result handshake from a functional unit into its result queue.

interface fu_result_queue_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_ready;

  modport master (output result_valid, output result, input  result_ready);
  modport slave  (input  result_valid, input  result, output result_ready);
endinterface

// File: rtl/fu_result_queue.sv
// Per-functional-unit result buffer: small in-order circular FIFO between one
// functional unit's output and the retirement arbiter.

package fu_pkg;
  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MUL    = 3'd1,
    FU_LSU    = 3'd2,
    FU_BRANCH = 3'd3,
    FU_CSR    = 3'd4
  } e_functional_unit;

  localparam int FU_CNT = 5;
endpackage

module fu_result_queue
  import fu_pkg::*;
#(
  parameter int               DATA_WIDTH = 64,
  parameter int               DEPTH      = 4,
  parameter e_functional_unit UNIT       = e_functional_unit'(0)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  fu_result_queue_if.slave             res_if,
  output logic                         retirement_ready_o,
  output logic [DATA_WIDTH-1:0]        unit_result_o,
  input  e_functional_unit             unit_retire_i,
  input  logic                         retire_en_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fu_result_queue: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push;
  logic                  pop;

  // Ready looks only at registered occupancy, so a same-cycle pop never
  // frees a slot for a push and the grant has no path to result_ready.
  assign res_if.result_ready = (count < CNT_W'(DEPTH)) && !rst_i;
  assign retirement_ready_o  = (count != '0);
  assign unit_result_o       = retirement_ready_o ? mem[rd_ptr] : '0;
  assign count_o             = count;

  assign push = res_if.result_valid && res_if.result_ready;
  assign pop  = retire_en_i && (unit_retire_i == UNIT) && retirement_ready_o;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; the empty check masks stale data.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= res_if.result;
  end

endmodule

// File: tb/tb_fu_result_queue.sv
// Directed self-checking bench for fu_result_queue (DEPTH 4, UNIT = FU_LSU).

module tb_fu_result_queue;
  import fu_pkg::*;

  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             retirement_ready_o;
  logic [DW-1:0]    unit_result_o;
  e_functional_unit unit_retire_i;
  logic             retire_en_i;
  logic [2:0]       count_o;

  int n_checks = 0;
  int n_fail   = 0;

  fu_result_queue_if #(.DATA_WIDTH(DW)) res_if ();

  fu_result_queue #(
    .DATA_WIDTH(DW),
    .DEPTH     (4),
    .UNIT      (FU_LSU)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .res_if            (res_if.slave),
    .retirement_ready_o(retirement_ready_o),
    .unit_result_o     (unit_result_o),
    .unit_retire_i     (unit_retire_i),
    .retire_en_i       (retire_en_i),
    .count_o           (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] v);
    res_if.result_valid = 1'b1;
    res_if.result       = v;
    tick();
    res_if.result_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i               = 1'b1;
    flush_i             = 1'b0;
    res_if.result_valid = 1'b1;
    res_if.result       = 64'hDEAD;
    unit_retire_i       = FU_ALU;
    retire_en_i         = 1'b0;

    // Reset held for two edges with a result presented
    #1;
    check("ready_in_reset_0", res_if.result_ready, 0);
    tick();
    check("ready_in_reset_1", res_if.result_ready, 0);
    tick();
    check("ready_in_reset_2", res_if.result_ready, 0);
    rst_i               = 1'b0;
    res_if.result_valid = 1'b0;
    #1;
    check("rst_count",     count_o, 0);
    check("rst_ret_ready", retirement_ready_o, 0);
    check("rst_head",      unit_result_o, 0);
    check("rst_ready",     res_if.result_ready, 1);

    // Fill to DEPTH, then try one more push
    for (int i = 1; i <= 4; i++) push_one(64'h11 * i);
    check("full_ready", res_if.result_ready, 0);
    check("full_count", count_o, 4);
    push_one(64'h55);
    check("overfill_count", count_o, 4);
    check("overfill_head",  unit_result_o, 64'h11);

    // Drain in order
    unit_retire_i = FU_LSU;
    retire_en_i   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", retirement_ready_o, 1);
      check("drain_head",  unit_result_o, 64'h11 * i);
      tick();
    end
    check("drained_valid", retirement_ready_o, 0);
    check("drained_count", count_o, 0);

    // Grant while empty is ignored
    tick();
    check("empty_grant_count", count_o, 0);
    retire_en_i = 1'b0;

    // Foreign and idle grants
    push_one(64'hAB);
    check("one_count", count_o, 1);
    retire_en_i = 1'b1;
    unit_retire_i = FU_ALU;    tick();
    unit_retire_i = FU_MUL;    tick();
    unit_retire_i = FU_BRANCH; tick();
    check("foreign_count", count_o, 1);
    check("foreign_head",  unit_result_o, 64'hAB);
    retire_en_i   = 1'b0;
    unit_retire_i = FU_LSU;
    tick();
    check("idle_count", count_o, 1);
    check("idle_head",  unit_result_o, 64'hAB);
    retire_en_i = 1'b1;
    tick();
    retire_en_i = 1'b0;
    check("own_grant_count", count_o, 0);

    // Streaming push+pop through two pointer wraps
    for (int i = 1; i <= 10; i++) begin
      res_if.result_valid = 1'b1;
      res_if.result       = 64'(i);
      retire_en_i         = (i > 1);
      if (i > 1) begin
        check("stream_count", count_o, 1);
        check("stream_head",  unit_result_o, 64'(i - 1));
      end
      tick();
    end
    res_if.result_valid = 1'b0;
    retire_en_i         = 1'b1;
    check("stream_last_head", unit_result_o, 64'd10);
    tick();
    retire_en_i = 1'b0;
    check("stream_end_count", count_o, 0);

    // Full plus pop: pop happens, push is refused
    for (int i = 1; i <= 4; i++) push_one(64'hA0 + i);
    res_if.result_valid = 1'b1;
    res_if.result       = 64'hA5;
    retire_en_i         = 1'b1;
    check("fullpop_ready", res_if.result_ready, 0);
    tick();
    res_if.result_valid = 1'b0;
    check("fullpop_count", count_o, 3);
    for (int i = 2; i <= 4; i++) begin
      check("fullpop_drain", unit_result_o, 64'hA0 + i);
      tick();
    end
    retire_en_i = 1'b0;
    check("fullpop_empty", count_o, 0);

    // Flush beats a simultaneous push and grant
    push_one(64'hB1);
    push_one(64'hB2);
    check("preflush_count", count_o, 2);
    flush_i             = 1'b1;
    res_if.result_valid = 1'b1;
    res_if.result       = 64'hB3;
    retire_en_i         = 1'b1;
    tick();
    flush_i             = 1'b0;
    retire_en_i         = 1'b0;
    res_if.result_valid = 1'b0;
    check("flush_count",     count_o, 0);
    check("flush_ret_ready", retirement_ready_o, 0);
    check("flush_head",      unit_result_o, 0);
    res_if.result_valid = 1'b1;
    res_if.result       = 64'h77;
    check("no_bypass", retirement_ready_o, 0);
    tick();
    res_if.result_valid = 1'b0;
    check("post_flush_count", count_o, 1);
    check("post_flush_head",  unit_result_o, 64'h77);
    check("post_flush_valid", retirement_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
